// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: VGA read port, BG read-modify-write port and SRAM
// control/address pins. The bidirectional SRAM data bus stays a plain module port.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20
) ();

  // VGA read port
  logic              i_vga_req;
  logic [ADDR_W-1:0] i_vga_addr;
  logic [15:0]       o_vga_rdata;
  logic              o_vga_rvalid;
  logic              o_vga_miss;

  // BG burst port
  logic              i_bg_req;
  logic [ADDR_W-1:0] i_bg_addr;
  logic              o_bg_gnt;
  logic              o_bg_busy;
  logic [15:0]       o_bg_rdata;
  logic              o_bg_rvalid;
  logic [15:0]       i_bg_wdata;
  logic              o_bg_wack;

  // SRAM pins
  logic [ADDR_W-1:0] o_sram_addr;
  logic              o_sram_ce_n;
  logic              o_sram_oe_n;
  logic              o_sram_we_n;

  // Arbiter side
  modport slave (
    input  i_vga_req, i_vga_addr, i_bg_req, i_bg_addr, i_bg_wdata,
    output o_vga_rdata, o_vga_rvalid, o_vga_miss,
    output o_bg_gnt, o_bg_busy, o_bg_rdata, o_bg_rvalid, o_bg_wack,
    output o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n
  );

  // Client / environment side
  modport master (
    output i_vga_req, i_vga_addr, i_bg_req, i_bg_addr, i_bg_wdata,
    input  o_vga_rdata, o_vga_rvalid, o_vga_miss,
    input  o_bg_gnt, o_bg_busy, o_bg_rdata, o_bg_rvalid, o_bg_wack,
    input  o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n
  );

endinterface

// File: rtl/sram_arbiter.sv
// Single-port asynchronous SRAM arbiter between a VGA read stream and a background-
// subtraction read-modify-write burst (RD0, RD1, CALC, WR0, WR1 on a pixel pair).
// VGA wins the bus every cycle it asks; the BG burst holds its phase while stalled.
// Optional starvation guard: define SRAM_ARB_STARVE_GUARD_EN to let a BG phase take
// the bus after STARVE_MAX consecutive stalls, dropping that cycle's VGA request.
module sram_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sram_arbiter_if.slave  bus,
  inout  wire [15:0]     sram_dq
);

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StCalc,
    StWr0,
    StWr1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic read_phase;    // RD0 / RD1
  logic write_phase;   // WR0 / WR1
  logic access_phase;  // any phase that needs the SRAM
  logic hi_word;       // second word of the pixel pair
  logic guard_fire;    // BG overrides VGA this cycle
  logic vga_win;       // VGA owns the bus this cycle
  logic bg_go;         // BG owns the bus this cycle
  logic dq_oe;

  logic [15:0] vga_rdata_q;
  logic        vga_rvalid_q;
  logic [15:0] bg_rdata_q;
  logic        bg_rvalid_q;

  // Only the pair-aligned part of the BG address is used.
  logic unused_bg_addr_lsb;
  assign unused_bg_addr_lsb = bus.i_bg_addr[0];

  // Phase decode
  always_comb begin
    read_phase   = (state_q == StRd0) || (state_q == StRd1);
    write_phase  = (state_q == StWr0) || (state_q == StWr1);
    access_phase = read_phase || write_phase;
    hi_word      = (state_q == StRd1) || (state_q == StWr1);
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

  // Guard trips once the current phase has been stalled STARVE_MAX cycles in a row
  always_comb begin
    guard_fire  = !i_rst && access_phase && bus.i_vga_req &&
                  (stall_cnt_q == CntW'(STARVE_MAX));
    // Counts only stalls of the current phase; any BG bus cycle or non-access state clears
    stall_cnt_d = (access_phase && vga_win) ? stall_cnt_q + 1'b1 : '0;
  end

  // Stall counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  // VGA always wins without the guard
  always_comb guard_fire = 1'b0;
`endif

  // Bus ownership
  always_comb begin
    vga_win = !i_rst && bus.i_vga_req && !guard_fire;
    bg_go   = !i_rst && access_phase && !vga_win;
  end

  // Next-state: BG phases advance only on cycles they own the bus; CALC never waits
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_bg_req) begin
          state_d = StRd0;
          base_d  = {bus.i_bg_addr[ADDR_W-1:1], 1'b0};
        end
      end
      StRd0:   if (bg_go) state_d = StRd1;
      StRd1:   if (bg_go) state_d = StCalc;
      StCalc:  state_d = StWr0;
      StWr0:   if (bg_go) state_d = StWr1;
      StWr1:   if (bg_go) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and burst base register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // SRAM controls and handshake outputs, all inactive while reset is asserted
  always_comb begin
    bus.o_sram_ce_n = 1'b1;
    bus.o_sram_oe_n = 1'b1;
    bus.o_sram_we_n = 1'b1;
    bus.o_sram_addr = '0;
    bus.o_bg_wack   = 1'b0;
    dq_oe           = 1'b0;
    if (vga_win) begin
      bus.o_sram_ce_n = 1'b0;
      bus.o_sram_oe_n = 1'b0;
      bus.o_sram_addr = bus.i_vga_addr;
    end else if (bg_go) begin
      bus.o_sram_ce_n = 1'b0;
      bus.o_sram_oe_n = !read_phase;
      bus.o_sram_we_n = !write_phase;
      bus.o_sram_addr = {base_q[ADDR_W-1:1], hi_word};
      bus.o_bg_wack   = write_phase;
      dq_oe           = write_phase;
    end
    bus.o_bg_gnt   = !i_rst && (state_q == StIdle) && bus.i_bg_req;
    bus.o_bg_busy  = !i_rst && (state_q != StIdle);
    bus.o_vga_miss = guard_fire;
  end

  assign sram_dq = dq_oe ? bus.i_bg_wdata : 16'hzzzz;

  // Capture read data at the end of the read cycle; valid for the following cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vga_rdata_q  <= '0;
      vga_rvalid_q <= 1'b0;
      bg_rdata_q   <= '0;
      bg_rvalid_q  <= 1'b0;
    end else begin
      vga_rvalid_q <= vga_win;
      bg_rvalid_q  <= bg_go && read_phase;
      if (vga_win) begin
        vga_rdata_q <= sram_dq;
      end
      if (bg_go && read_phase) begin
        bg_rdata_q <= sram_dq;
      end
    end
  end

  // Registered read-return outputs
  always_comb begin
    bus.o_vga_rdata  = vga_rdata_q;
    bus.o_vga_rvalid = vga_rvalid_q;
    bus.o_bg_rdata   = bg_rdata_q;
    bus.o_bg_rvalid  = bg_rvalid_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, phase-level reference model,
// directed scenarios and a randomized run.
module tb_sram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned SM = 8;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) bus ();
  wire [15:0] sram_dq;

  sram_arbiter #(
    .ADDR_W    (AW),
    .STARVE_MAX(SM)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .sram_dq(sram_dq)
  );

  // Behavioural asynchronous SRAM (low 10 address bits)
  logic [15:0] sram_mem [1024];
  wire sram_drive = !bus.o_sram_ce_n && !bus.o_sram_oe_n && bus.o_sram_we_n;
  assign sram_dq = sram_drive ? sram_mem[bus.o_sram_addr[9:0]] : 16'hzzzz;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ph = -1 idle, 0 RD0, 1 RD1, 2 CALC, 3 WR0, 4 WR1
  int          ph;
  logic [AW-1:0] base;
  int          stall;
  logic        m_vrv, m_brv;
  logic [15:0] m_vrd, m_brd;
  logic [15:0] ref_mem [1024];
  logic        e_ce_n, e_oe_n, e_we_n, e_gnt, e_busy, e_wack, e_miss;
  logic [AW-1:0] e_addr;
  logic        e_vwin, e_bgo, e_acc;

  task automatic model_eval();
    logic fire;
    e_acc = (ph == 0) || (ph == 1) || (ph == 3) || (ph == 4);
    fire  = Guard && e_acc && bus.i_vga_req && (stall == int'(SM));
    if (rst) begin
      e_vwin = 1'b0;
      e_bgo  = 1'b0;
      fire   = 1'b0;
    end else begin
      e_vwin = bus.i_vga_req && !fire;
      e_bgo  = e_acc && !e_vwin;
    end
    e_ce_n = !(e_vwin || e_bgo);
    e_oe_n = !(e_vwin || (e_bgo && ph < 2));
    e_we_n = !(e_bgo && ph >= 3);
    if (e_vwin)     e_addr = bus.i_vga_addr;
    else if (e_bgo) e_addr = base + AW'((ph == 1 || ph == 4) ? 1 : 0);
    else            e_addr = '0;
    e_gnt  = !rst && (ph < 0) && bus.i_bg_req;
    e_busy = !rst && (ph >= 0);
    e_wack = e_bgo && (ph >= 3);
    e_miss = fire;
  endtask

  task automatic model_commit();
    if (rst) begin
      ph = -1; stall = 0;
      m_vrv = 1'b0; m_brv = 1'b0; m_vrd = '0; m_brd = '0;
    end else begin
      m_vrv = e_vwin;
      if (e_vwin) m_vrd = ref_mem[e_addr[9:0]];
      m_brv = e_bgo && (ph < 2);
      if (m_brv) m_brd = ref_mem[e_addr[9:0]];
      if (e_bgo && ph >= 3) ref_mem[e_addr[9:0]] = bus.i_bg_wdata;
      stall = (e_acc && e_vwin) ? stall + 1 : 0;
      if (ph < 0) begin
        if (bus.i_bg_req) begin
          ph   = 0;
          base = {bus.i_bg_addr[AW-1:1], 1'b0};
        end
      end else if (ph == 2) begin
        ph = 3;
      end else if (e_bgo) begin
        ph = (ph == 4) ? -1 : ph + 1;
      end
    end
  endtask

  function automatic logic [60:0] obs_vec();
    return {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_addr,
            bus.o_bg_gnt, bus.o_bg_busy, bus.o_bg_wack, bus.o_vga_miss,
            bus.o_vga_rvalid, bus.o_vga_rdata, bus.o_bg_rvalid, bus.o_bg_rdata};
  endfunction

  function automatic logic [60:0] exp_vec();
    return {e_ce_n, e_oe_n, e_we_n, e_addr, e_gnt, e_busy, e_wack, e_miss,
            m_vrv, m_vrd, m_brv, m_brd};
  endfunction

  task automatic drive(input logic vreq, input logic [AW-1:0] vaddr, input logic breq,
                       input logic [AW-1:0] baddr, input logic [15:0] wdata);
    bus.i_vga_req  = vreq;
    bus.i_vga_addr = vaddr;
    bus.i_bg_req   = breq;
    bus.i_bg_addr  = baddr;
    bus.i_bg_wdata = wdata;
  endtask

  // Settle just before the rising edge, evaluate model, let the SRAM absorb writes
  task automatic settle();
    #4;
    model_eval();
    if (!bus.o_sram_ce_n && !bus.o_sram_we_n) sram_mem[bus.o_sram_addr[9:0]] = sram_dq;
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, AW'(5), 1'b1, AW'(8), 16'h1234);
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if ({bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n} !== 3'b111 ||
          bus.o_sram_addr !== '0) begin
        n_fail++;
        $display("FAIL reset_sram cyc %0d: ctl %b addr %h, want 111 addr 0", k,
                 {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n}, bus.o_sram_addr);
      end
      n_checks++;
      if ({bus.o_bg_gnt, bus.o_bg_busy, bus.o_bg_wack, bus.o_vga_miss} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_flags cyc %0d: gnt/busy/wack/miss %b, want 0000", k,
                 {bus.o_bg_gnt, bus.o_bg_busy, bus.o_bg_wack, bus.o_vga_miss});
      end
      step();
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if ({bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_vga_rvalid,
           bus.o_bg_rvalid, bus.o_vga_rdata, bus.o_bg_rdata} !== {3'b111, 2'b00, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: ctl %b rvalid %b rdata %h/%h, want 111 00 0/0", k,
                 {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n},
                 {bus.o_vga_rvalid, bus.o_bg_rvalid}, bus.o_vga_rdata, bus.o_bg_rdata);
      end
      step();
    end
  endtask

  task automatic test_burst();
    logic [AW-1:0] t_addr [5];
    logic [2:0]    t_ctl  [5];
    logic          t_wack [5];
    logic          t_brv  [5];
    int busy_n = 0;
    t_addr = '{AW'('h100), AW'('h101), AW'(0), AW'('h100), AW'('h101)};
    t_ctl  = '{3'b001, 3'b001, 3'b111, 3'b010, 3'b010};
    t_wack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t_brv  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    drive(1'b0, '0, 1'b1, AW'('h00101), 16'hBEEF);
    for (int k = 0; k <= 6; k++) begin
      settle();
      if (bus.o_bg_busy) busy_n++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL burst_model cyc %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 0) begin
        n_checks++;
        if ({bus.o_bg_gnt, bus.o_bg_busy, bus.o_sram_ce_n} !== 3'b101) begin
          n_fail++;
          $display("FAIL burst_gnt: gnt/busy/ce_n %b, want 101",
                   {bus.o_bg_gnt, bus.o_bg_busy, bus.o_sram_ce_n});
        end
      end else if (k <= 5) begin
        n_checks++;
        if ({bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_addr,
             bus.o_bg_wack, bus.o_bg_rvalid, bus.o_bg_gnt} !==
            {t_ctl[k-1], t_addr[k-1], t_wack[k-1], t_brv[k-1], 1'b0}) begin
          n_fail++;
          $display("FAIL burst_phase cyc %0d: ctl %b addr %h wack %b rvalid %b, want %b %h %b %b",
                   k, {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n}, bus.o_sram_addr,
                   bus.o_bg_wack, bus.o_bg_rvalid, t_ctl[k-1], t_addr[k-1], t_wack[k-1],
                   t_brv[k-1]);
        end
        if (k >= 4) begin
          n_checks++;
          if (sram_dq !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL burst_wdata cyc %0d: dq %h, want beef", k, sram_dq);
          end
        end
      end
      step();
      bus.i_bg_req = 1'b0;
    end
    n_checks++;
    if (busy_n != 5) begin
      n_fail++;
      $display("FAIL burst_busy_len: %0d cycles, want 5", busy_n);
    end
  endtask

  task automatic test_vga_stall();
    int vrv_n = 0, brv_n = 0, wack_n = 0, last_brv = -1, first_wack = -1, clash = 0;
    logic [AW-1:0] b;
    b = AW'($urandom_range(0, 1023));
    for (int k = 0; k < 12; k++) begin
      drive((k >= 2 && k <= 4), AW'($urandom_range(0, 1023)), (k == 0), b, 16'h0F0F + 16'(k));
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL vga_stall_model cyc %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (bus.o_vga_rvalid) vrv_n++;
      if (bus.o_bg_rvalid) begin brv_n++; last_brv = k; end
      if (bus.o_bg_wack) begin wack_n++; if (first_wack < 0) first_wack = k; end
      if (!bus.o_sram_oe_n && !bus.o_sram_we_n) clash++;
      step();
    end
    n_checks++;
    if (vrv_n != 3 || brv_n != 2 || wack_n != 2 || clash != 0) begin
      n_fail++;
      $display("FAIL vga_stall_counts: vrv %0d brv %0d wack %0d clash %0d, want 3 2 2 0",
               vrv_n, brv_n, wack_n, clash);
    end
    // RD1 held to cycle 5, data valid in CALC (6), WR0 at 7
    n_checks++;
    if (last_brv != 6 || first_wack != 7) begin
      n_fail++;
      $display("FAIL vga_stall_order: last bg rvalid %0d first wack %0d, want 6 7",
               last_brv, first_wack);
    end
  endtask

  task automatic test_guard();
    int miss_n = 0, vrv_n = 0;
    logic [AW-1:0] b;
    b = AW'($urandom_range(0, 1023));
    for (int k = 0; k < 56; k++) begin
      drive((k >= 1 && k <= 45), AW'($urandom_range(0, 1023)), (k == 0), b,
            16'($urandom));
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL guard_model cyc %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (bus.o_vga_miss) miss_n++;
      if (bus.o_vga_rvalid) vrv_n++;
      step();
    end
    n_checks++;
    if (miss_n != (Guard ? 4 : 0) || vrv_n != (Guard ? 41 : 45)) begin
      n_fail++;
      $display("FAIL guard_counts: miss %0d vga rvalid %0d, want %0d %0d", miss_n, vrv_n,
               Guard ? 4 : 0, Guard ? 41 : 45);
    end
    settle();
    n_checks++;
    if (bus.o_bg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL guard_done: busy %b, want 0", bus.o_bg_busy);
    end
    step();
  endtask

  task automatic test_reset_in_calc();
    logic [AW-1:0] b;
    b = AW'($urandom_range(0, 1023));
    for (int k = 0; k < 7; k++) begin
      rst = (k == 3);
      drive(1'b0, '0, (k == 0 || k == 4), (k == 4) ? b ^ AW'('h2) : b, 16'hA5A5);
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_calc_model cyc %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 3 || k == 4) begin
        n_checks++;
        if (bus.o_sram_we_n !== 1'b1 || bus.o_sram_ce_n !== 1'b1 || bus.o_bg_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_calc_nowrite cyc %0d: we_n %b ce_n %b busy %b, want 1 1 0", k,
                   bus.o_sram_we_n, bus.o_sram_ce_n, bus.o_bg_busy);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (bus.o_bg_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_calc_regrant: gnt %b, want 1", bus.o_bg_gnt);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.o_sram_oe_n !== 1'b0 || bus.o_sram_addr !== {(b[AW-1:1] ^ (AW-1)'(1)), 1'b0}) begin
          n_fail++;
          $display("FAIL rst_calc_rd0: oe_n %b addr %h, want 0 %h", bus.o_sram_oe_n,
                   bus.o_sram_addr, {(b[AW-1:1] ^ (AW-1)'(1)), 1'b0});
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 99) < 35), AW'($urandom_range(0, 1023)),
            ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 1023)), 16'($urandom));
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (!e_we_n) begin
        n_checks++;
        if (sram_dq !== bus.i_bg_wdata) begin
          n_fail++;
          $display("FAIL random_wdata cyc %0d: dq %h, want %h", k, sram_dq, bus.i_bg_wdata);
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 16'(i * 947) ^ 16'h5A5A;
      ref_mem[i]  = 16'(i * 947) ^ 16'h5A5A;
    end
    ph = -1; stall = 0; base = '0;
    m_vrv = 1'b0; m_brv = 1'b0; m_vrd = '0; m_brd = '0;
    drive(1'b0, '0, 1'b0, '0, 16'h0);
    @(negedge clk);
    test_reset();
    test_burst();
    test_vga_stall();
    test_guard();
    test_reset_in_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning SRAM word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning the stall limit for a background-subtraction (BG) burst phase.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_vga_req, input, 1 bit: VGA read request for this cycle.
REQ-006 SHALL have port i_vga_addr, input, ADDR_W bits: VGA read address.
REQ-007 SHALL have port o_vga_rdata, output, 16 bits: VGA read data.
REQ-008 SHALL have port o_vga_rvalid, output, 1 bit: o_vga_rdata is valid.
REQ-009 SHALL have port o_vga_miss, output, 1 bit: a VGA request was dropped.
REQ-010 SHALL have port i_bg_req, input, 1 bit: BG read-modify-write burst request.
REQ-011 SHALL have port i_bg_addr, input, ADDR_W bits: BG pixel base address (even).
REQ-012 SHALL have port o_bg_gnt, output, 1 bit: one-cycle burst grant.
REQ-013 SHALL have port o_bg_busy, output, 1 bit: a BG burst is in progress.
REQ-014 SHALL have port o_bg_rdata, output, 16 bits: BG read data.
REQ-015 SHALL have port o_bg_rvalid, output, 1 bit: o_bg_rdata is valid.
REQ-016 SHALL have port i_bg_wdata, input, 16 bits: BG write data.
REQ-017 SHALL have port o_bg_wack, output, 1 bit: i_bg_wdata was consumed this cycle.
REQ-018 SHALL have port o_sram_addr, output, ADDR_W bits: SRAM address.
REQ-019 SHALL have ports o_sram_ce_n, o_sram_oe_n and o_sram_we_n, outputs, 1 bit each, active-low: SRAM chip enable, output enable and write enable.
REQ-020 SHALL have port sram_dq, inout, 16 bits: SRAM data bus.

Function
REQ-021 SHALL implement the states IDLE, RD0, RD1, CALC, WR0 and WR1.
REQ-022 In IDLE with i_bg_req high, SHALL pulse o_bg_gnt, latch {i_bg_addr[ADDR_W-1:1],1'b0} as base, and enter RD0 on the next cycle.
REQ-023 Burst phases SHALL be: RD0 reads base, RD1 reads base+1, CALC is a one-cycle bus-idle gap, WR0 writes base, WR1 writes base+1; WR1 then returns to IDLE.
REQ-024 i_vga_req SHALL win the bus in any cycle; in RD0, RD1, WR0 or WR1 the BG phase SHALL then hold its state; in IDLE and CALC VGA use SHALL cause no BG stall.
REQ-025 SRAM controls SHALL be combinational from state and i_vga_req: ce_n=0 on any access; oe_n=0 on reads; we_n=0 and sram_dq driven on writes; sram_dq SHALL be high-Z otherwise.
REQ-026 Read data SHALL be registered at the end of the read cycle, with o_vga_rvalid or o_bg_rvalid high for exactly the following cycle.
REQ-027 o_bg_wack SHALL be high only in a WR0/WR1 cycle that owns the bus; i_bg_wdata SHALL be sampled in that cycle.
REQ-028 The RD1 data (valid during CALC) SHALL precede WR0 by at least one cycle.
REQ-029 o_bg_busy SHALL be high in RD0 through WR1 inclusive.
REQ-030 i_bg_req in a non-IDLE state SHALL be ignored.
REQ-031 A VGA read and a BG access SHALL never share a cycle.

Reset
REQ-032 On i_rst, state SHALL go to IDLE with any burst abandoned and no write issued.
REQ-033 On i_rst, the stall counter SHALL be cleared.
REQ-034 On i_rst, o_vga_rdata and o_bg_rdata SHALL be 0.
REQ-035 On i_rst, all valid, gnt, busy, wack and miss outputs SHALL be 0.
REQ-036 On i_rst, o_sram_ce_n, o_sram_oe_n and o_sram_we_n SHALL be 1.
REQ-037 On i_rst, sram_dq SHALL be high-Z and o_sram_addr SHALL be 0.

Configuration
REQ-038 With macro SRAM_ARB_STARVE_GUARD_EN defined, a counter SHALL count consecutive stalled cycles of the current BG phase.
REQ-039 With the guard, when the count equals STARVE_MAX the BG phase SHALL take the bus, the VGA request SHALL be dropped, o_vga_miss SHALL pulse, and the counter SHALL clear.
REQ-040 The stall counter SHALL also clear on every phase advance.
REQ-041 Without SRAM_ARB_STARVE_GUARD_EN, VGA SHALL always win, o_vga_miss SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-042 Reset, then idle -> all control outputs 1, sram_dq Z, rvalid outputs 0.
REQ-043 i_bg_req with i_bg_addr=0x00101 and no VGA traffic -> gnt at cycle 0; RD0 addr 0x00100; RD1 0x00101; CALC; WR0 0x00100 with dq=i_bg_wdata; WR1 0x00101; busy for 5 cycles.
REQ-044 BG burst with i_vga_req high for 3 cycles during RD1 -> VGA reads served, RD1 held 3 cycles, wack and rvalid ordering preserved, no dq contention.
REQ-045 Guard on, STARVE_MAX=8, i_vga_req held high through WR0 -> after 8 stalls WR0 writes, o_vga_miss=1 for one cycle, VGA resumes the next cycle.
REQ-046 i_rst asserted in CALC -> no write occurs, IDLE on the next cycle, a new i_bg_req is granted normally.
